// File: rtl/backprop_sequencer.sv
// -----------------------------------------------------------------------------
// backprop_sequencer
//
// Master-side driver for the backpropagator. For every training sample it
// walks the layers from LAYER_MAX down to 0. For each layer it issues one token
// on the layer, sample, z and z_prev streams. It then waits for the updated
// weight matrix before it moves on to the next layer. The z vectors come from
// an activation buffer that the forward pass fills.
//
// Optional feature (compile-time macro BACKPROP_SEQ_ERROR_HALT_EN):
//   defined   - error while in ISSUE or WAIT_W ends the run. The open
//               handshakes and the pending weights token still complete,
//               then the block goes to DONE.
//   undefined - error only sets the sticky error_seen flag.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start, sample_count            run request (count 0 = no-op, done only)
//   busy, done                     run in progress / one-cycle end pulse
//   act_wr_en/addr/data            activation buffer write port
//   layer/_valid/_ready            layer index stream (out)
//   sample/_valid/_ready           sample index stream (out)
//   z/_valid/_ready                activation of layer L   (buffer entry L+1)
//   z_prev/_valid/_ready           activation feeding L    (buffer entry L)
//   weights/_valid/_ready          updated weight matrix (in)
//   weights_last                   last accepted weight matrix
//   error, error_seen              overflow flag in / sticky copy out
// -----------------------------------------------------------------------------
module backprop_sequencer #(
    parameter int NEURON_NUM          = 4,
    parameter int NEURON_OUTPUT_WIDTH = 10,
    parameter int WEIGHT_CELL_WIDTH   = 16,
    parameter int LAYER_ADDR_WIDTH    = 1,
    parameter int LAYER_MAX           = 0,
    parameter int SAMPLE_ADDR_SIZE    = 10
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic [SAMPLE_ADDR_SIZE-1:0]                       sample_count,
    output logic                                              busy,
    output logic                                              done,
    input  logic                                              act_wr_en,
    input  logic [LAYER_ADDR_WIDTH:0]                         act_wr_addr,
    input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]         act_wr_data,
    output logic [LAYER_ADDR_WIDTH-1:0]                       layer,
    output logic                                              layer_valid,
    input  logic                                              layer_ready,
    output logic [SAMPLE_ADDR_SIZE-1:0]                       sample,
    output logic                                              sample_valid,
    input  logic                                              sample_ready,
    output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]         z,
    output logic                                              z_valid,
    input  logic                                              z_ready,
    output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]         z_prev,
    output logic                                              z_prev_valid,
    input  logic                                              z_prev_ready,
    input  logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] weights,
    input  logic                                              weights_valid,
    output logic                                              weights_ready,
    output logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] weights_last,
    input  logic                                              error,
    output logic                                              error_seen
);

    localparam int VW    = NEURON_NUM * NEURON_OUTPUT_WIDTH;
    localparam int WW    = NEURON_NUM * NEURON_NUM * WEIGHT_CELL_WIDTH;
    localparam int AW    = LAYER_ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** AW;

    localparam logic [LAYER_ADDR_WIDTH-1:0] LAYER_TOP = LAYER_ADDR_WIDTH'(LAYER_MAX);
    localparam logic [AW-1:0]               ADDR_TOP  = AW'(LAYER_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_W,
        S_DONE
    } state_e;

    state_e                        state_q, state_d;
    logic [LAYER_ADDR_WIDTH-1:0]   layer_q, layer_d;
    logic [SAMPLE_ADDR_SIZE-1:0]   sample_q, sample_d;
    logic [SAMPLE_ADDR_SIZE-1:0]   count_q, count_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          layer_valid_q, layer_valid_d;
    logic                          sample_valid_q, sample_valid_d;
    logic                          z_valid_q, z_valid_d;
    logic                          z_prev_valid_q, z_prev_valid_d;
    logic                          weights_ready_q, weights_ready_d;
    logic [WW-1:0]                 weights_last_q, weights_last_d;
    logic                          error_seen_q, error_seen_d;

    // The activation buffer has a power-of-two depth so that the index width
    // matches exactly. Entries above LAYER_MAX+1 are never written or read.
    logic [VW-1:0]                 act_mem_q [DEPTH];
    logic [AW-1:0]                 z_idx;
    logic [AW-1:0]                 z_prev_idx;

    logic [SAMPLE_ADDR_SIZE:0]     next_sample;
    logic                          more_samples;
    logic                          stop_run;

`ifdef BACKPROP_SEQ_ERROR_HALT_EN
    logic                          halt_q, halt_d;
`endif

    // -------------------------------------------------------------------------
    // Activation buffer
    // -------------------------------------------------------------------------
    // NOTE: the buffer has no reset. It is plain storage, and the forward pass
    // always writes an entry before any run reads it.
    always_ff @(posedge clk) begin
        if (act_wr_en && (act_wr_addr <= ADDR_TOP)) begin
            act_mem_q[act_wr_addr] <= act_wr_data;
        end
    end

    assign z_idx      = AW'(layer_q) + AW'(1);
    assign z_prev_idx = AW'(layer_q);
    assign z          = act_mem_q[z_idx];
    assign z_prev     = act_mem_q[z_prev_idx];

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    assign next_sample  = {1'b0, sample_q} + (SAMPLE_ADDR_SIZE + 1)'(1);
    assign more_samples = next_sample < {1'b0, count_q};

    // NOTE: every signal gets a default before the case statement. A path
    // that does not assign a signal would otherwise infer a latch.
    always_comb begin
        state_d         = state_q;
        layer_d         = layer_q;
        sample_d        = sample_q;
        count_d         = count_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        layer_valid_d   = layer_valid_q;
        sample_valid_d  = sample_valid_q;
        z_valid_d       = z_valid_q;
        z_prev_valid_d  = z_prev_valid_q;
        weights_ready_d = weights_ready_q;
        weights_last_d  = weights_last_q;
        error_seen_d    = error_seen_q | (error & busy_q);

`ifdef BACKPROP_SEQ_ERROR_HALT_EN
        halt_d   = halt_q | (error & ((state_q == S_ISSUE) || (state_q == S_WAIT_W)));
        // An error seen in the same cycle as the weights handshake also ends the run.
        stop_run = halt_q | error;
`else
        stop_run = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_seen_d = 1'b0;
`ifdef BACKPROP_SEQ_ERROR_HALT_EN
                    halt_d       = 1'b0;
`endif
                    if (sample_count != '0) begin
                        busy_d         = 1'b1;
                        sample_d       = '0;
                        layer_d        = LAYER_TOP;
                        count_d        = sample_count;
                        layer_valid_d  = 1'b1;
                        sample_valid_d = 1'b1;
                        z_valid_d      = 1'b1;
                        z_prev_valid_d = 1'b1;
                        state_d        = S_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                // Each stream retires on its own handshake. The state moves
                // on once no valid is left pending.
                layer_valid_d  = layer_valid_q  & ~layer_ready;
                sample_valid_d = sample_valid_q & ~sample_ready;
                z_valid_d      = z_valid_q      & ~z_ready;
                z_prev_valid_d = z_prev_valid_q & ~z_prev_ready;
                if (!(layer_valid_d || sample_valid_d || z_valid_d || z_prev_valid_d)) begin
                    weights_ready_d = 1'b1;
                    state_d         = S_WAIT_W;
                end
            end

            S_WAIT_W: begin
                if (weights_valid && weights_ready_q) begin
                    weights_last_d  = weights;
                    weights_ready_d = 1'b0;
                    if (stop_run) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (layer_q != '0) begin
                        layer_d        = layer_q - LAYER_ADDR_WIDTH'(1);
                        layer_valid_d  = 1'b1;
                        sample_valid_d = 1'b1;
                        z_valid_d      = 1'b1;
                        z_prev_valid_d = 1'b1;
                        state_d        = S_ISSUE;
                    end else if (more_samples) begin
                        sample_d       = next_sample[SAMPLE_ADDR_SIZE-1:0];
                        layer_d        = LAYER_TOP;
                        layer_valid_d  = 1'b1;
                        sample_valid_d = 1'b1;
                        z_valid_d      = 1'b1;
                        z_prev_valid_d = 1'b1;
                        state_d        = S_ISSUE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // done_q is high during this cycle because it was set on entry.
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Flops then
    // all update together at the clock edge, whatever order the blocks run in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            layer_q         <= '0;
            sample_q        <= '0;
            count_q         <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            layer_valid_q   <= 1'b0;
            sample_valid_q  <= 1'b0;
            z_valid_q       <= 1'b0;
            z_prev_valid_q  <= 1'b0;
            weights_ready_q <= 1'b0;
            weights_last_q  <= '0;
            error_seen_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            layer_q         <= layer_d;
            sample_q        <= sample_d;
            count_q         <= count_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            layer_valid_q   <= layer_valid_d;
            sample_valid_q  <= sample_valid_d;
            z_valid_q       <= z_valid_d;
            z_prev_valid_q  <= z_prev_valid_d;
            weights_ready_q <= weights_ready_d;
            weights_last_q  <= weights_last_d;
            error_seen_q    <= error_seen_d;
        end
    end

`ifdef BACKPROP_SEQ_ERROR_HALT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end
`endif

    assign layer         = layer_q;
    assign sample        = sample_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign layer_valid   = layer_valid_q;
    assign sample_valid  = sample_valid_q;
    assign z_valid       = z_valid_q;
    assign z_prev_valid  = z_prev_valid_q;
    assign weights_ready = weights_ready_q;
    assign weights_last  = weights_last_q;
    assign error_seen    = error_seen_q;

endmodule
